stack_tos_engine: RTL

- Parametrised successor to the register-controlled stack/TOS datapath: a self-sequencing operand stack with a cached top-of-stack register, command handshake, depth tracking and error detection.
- Sits between the instruction decoder/ALU and the stack memory.
- Executes PUSH/POP/DUP/SWAP/REPL/BINOP commands without external per-register enables.
- Stack memory is internal, synchronous write, 1-cycle synchronous read.

---
 rtl/stack_tos_engine.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/stack_tos_engine.sv
// stack_tos_engine: self-sequencing operand stack with a cached top-of-stack
// register, command handshake, depth tracking and sticky error flags.
// Element at depth 1 lives in the TOS register; depth k>=2 lives in mem[count-k].
// Optional feature macro: STACK_WATERMARK_EN (adds the hwm high-water-mark output).
module stack_tos_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] tos,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  done,
    output logic                  err_ovf,
    output logic                  err_unf,
`ifdef STACK_WATERMARK_EN
    output logic                  err_ill,
    output logic [ADDR_WIDTH:0]   hwm
`else
    output logic                  err_ill
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ZERO = (ADDR_WIDTH + 1)'(0);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_TWO  = (ADDR_WIDTH + 1)'(2);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_DUP   = 3'b011;
    localparam logic [2:0] OP_SWAP  = 3'b100;
    localparam logic [2:0] OP_REPL  = 3'b101;
    localparam logic [2:0] OP_BINOP = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_FILL_SWAP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] tos_q, tos_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  ill_q, ill_d;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  accept_s;
    logic                  empty_s;
    logic                  full_s;
    logic [ADDR_WIDTH-1:0] addr_m1_s;
    logic [ADDR_WIDTH-1:0] addr_m2_s;
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_waddr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;
    logic                  mem_re_s;
    logic [ADDR_WIDTH-1:0] mem_raddr_s;

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept_s  = cmd_valid && cmd_ready;
    assign empty_s   = (count_q == CNT_ZERO);
    assign full_s    = (count_q == DEPTH_C);
    assign addr_m1_s = ADDR_WIDTH'(count_q - CNT_ONE);
    assign addr_m2_s = ADDR_WIDTH'(count_q - CNT_TWO);

    // State register: fill states are abandoned immediately on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: only a memory-reading POP/SWAP leaves IDLE, for exactly one cycle.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (cmd == OP_POP) && (count_q > CNT_ONE)) begin
                    state_d = ST_FILL;
                end else if (accept_s && (cmd == OP_SWAP) && (count_q >= CNT_TWO)) begin
                    state_d = ST_FILL_SWAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL:      state_d = ST_IDLE;
            ST_FILL_SWAP: state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Datapath/output decode: rejected commands only touch the error flags.
    always_comb begin
        tos_d       = tos_q;
        count_d     = count_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        ill_d       = ill_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = addr_m1_s;
        mem_wdata_s = tos_q;
        mem_re_s    = 1'b0;
        mem_raddr_s = addr_m2_s;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    done_d = 1'b1;
                    case (cmd)
                        OP_NOP: begin
                            tos_d = tos_q;
                        end
                        OP_PUSH: begin
                            if (full_s) begin
                                ovf_d = 1'b1;
                            end else begin
                                if (!empty_s) begin
                                    mem_we_s = 1'b1;
                                end else begin
                                    mem_we_s = 1'b0;
                                end
                                tos_d   = din;
                                count_d = count_q + CNT_ONE;
                            end
                        end
                        OP_POP: begin
                            if (empty_s) begin
                                unf_d = 1'b1;
                            end else if (count_q == CNT_ONE) begin
                                tos_d   = {DATA_WIDTH{1'b0}};
                                count_d = CNT_ZERO;
                            end else begin
                                // Completion is signalled from the FILL cycle instead.
                                mem_re_s = 1'b1;
                                count_d  = count_q - CNT_ONE;
                                done_d   = 1'b0;
                            end
                        end
                        OP_DUP: begin
                            if (empty_s) begin
                                unf_d = 1'b1;
                            end else if (full_s) begin
                                ovf_d = 1'b1;
                            end else begin
                                mem_we_s = 1'b1;
                                count_d  = count_q + CNT_ONE;
                            end
                        end
                        OP_SWAP: begin
                            if (count_q < CNT_TWO) begin
                                unf_d = 1'b1;
                            end else begin
                                mem_re_s = 1'b1;
                                done_d   = 1'b0;
                            end
                        end
                        OP_REPL: begin
                            if (empty_s) begin
                                unf_d = 1'b1;
                            end else begin
                                tos_d = din;
                            end
                        end
                        OP_BINOP: begin
                            if (count_q < CNT_TWO) begin
                                unf_d = 1'b1;
                            end else begin
                                tos_d   = din;
                                count_d = count_q - CNT_ONE;
                            end
                        end
                        default: begin
                            ill_d = 1'b1;
                        end
                    endcase
                end else begin
                    done_d = 1'b0;
                end
            end
            ST_FILL: begin
                // count was already decremented at acceptance.
                tos_d  = rd_data_q;
                done_d = 1'b1;
            end
            ST_FILL_SWAP: begin
                // Old TOS goes back to the slot just read; no read is pending now.
                tos_d       = rd_data_q;
                mem_we_s    = 1'b1;
                mem_waddr_s = addr_m2_s;
                mem_wdata_s = tos_q;
                done_d      = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
        if (err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
            ill_d = 1'b0;
        end else begin
            ovf_d = ovf_d;
        end
    end

    // Architectural registers: TOS, depth, completion pulse and sticky errors.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tos_q   <= {DATA_WIDTH{1'b0}};
            count_q <= CNT_ZERO;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            ill_q   <= ill_d;
        end
    end

    // Stack memory: synchronous write, registered read; contents are not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
        if (mem_re_s) begin
            rd_data_q <= mem_q[mem_raddr_s];
        end
    end

    assign tos     = tos_q;
    assign count   = count_q;
    assign empty   = empty_s;
    assign full    = full_s;
    assign done    = done_q;
    assign err_ovf = ovf_q;
    assign err_unf = unf_q;
    assign err_ill = ill_q;

`ifdef STACK_WATERMARK_EN
    logic [ADDR_WIDTH:0] hwm_q, hwm_d;

    // High-water mark tracks the deepest count seen; err_clr rebases it.
    always_comb begin
        if (err_clr) begin
            hwm_d = count_q;
        end else if (count_q > hwm_q) begin
            hwm_d = count_q;
        end else begin
            hwm_d = hwm_q;
        end
    end

    // High-water mark register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hwm_q <= CNT_ZERO;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

endmodule
